rd_weight_unit: RTL

- Streaming, parametrised symmetric-function unit for N-bit input words: a generalised successor to the fixed 8-input weight-bit (rd84-style) logic.
- Each accepted beat contributes its popcount to a frame accumulator. At the frame's last beat, the unit emits the total weight plus one selectable symmetric-function flag.
- Sits between an operand source and the result collector; valid/ready on both sides.
- A single-beat frame with MODE=BIT and sel=3 reproduces the 8-input "weight bit 3" function.

---
 rtl/rd_weight_unit_if.sv | 31 +++
 rtl/rd_weight_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rd_weight_unit_if.sv
// Operand-in / result-out handshake bundle for rd_weight_unit.
// master = source/collector side, slave = the unit.
interface rd_weight_unit_if #(
  parameter int N     = 8,
  parameter int ACC_W = 16,
  parameter int SEL_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             in_last;
  logic [1:0]       mode;
  logic [SEL_W-1:0] sel;
  logic [ACC_W-1:0] thresh;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_weight;
  logic             out_flag;
  logic             out_sat;
  logic [ACC_W-1:0] out_beats;

  modport master (
    output in_valid, in_data, in_last, mode, sel, thresh, out_ready,
    input  in_ready, out_valid, out_weight, out_flag, out_sat, out_beats
  );

  modport slave (
    input  in_valid, in_data, in_last, mode, sel, thresh, out_ready,
    output in_ready, out_valid, out_weight, out_flag, out_sat, out_beats
  );
endinterface

// File: rtl/rd_weight_unit.sv
// Streaming frame weight unit: popcount per beat, saturating frame accumulator,
// and one selectable symmetric-function flag reported at the end of each frame.
module rd_weight_unit #(
  parameter int N     = 8,
  parameter int ACC_W = 16,
  parameter int SEL_W = 4
) (
  input logic             clk,
  input logic             rst,
  rd_weight_unit_if.slave bus
);
  localparam int PC_W = $clog2(N + 1);
  localparam logic [1:0] MODE_EQ  = 2'b00;
  localparam logic [1:0] MODE_GE  = 2'b01;
  localparam logic [1:0] MODE_BIT = 2'b10;

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;
  state_t state_reg, state_next;

  logic             stall;
  logic             in_ready;
  logic             accept;
  logic [PC_W-1:0]  pc_next;

  logic             cfg_load;
  logic [1:0]       cfg_mode_reg;
  logic [SEL_W-1:0] cfg_sel_reg;
  logic [ACC_W-1:0] cfg_thresh_reg;
  logic [1:0]       eff_mode;
  logic [SEL_W-1:0] eff_sel;
  logic [ACC_W-1:0] eff_thresh;

  logic             s1_valid_reg;
  logic             s1_last_reg;
  logic [PC_W-1:0]  s1_pc_reg;
  logic [1:0]       s1_mode_reg;
  logic [SEL_W-1:0] s1_sel_reg;
  logic [ACC_W-1:0] s1_thresh_reg;

  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] beats_reg;
  logic             sat_reg;
  logic [ACC_W:0]   sum_wide;
  logic             clamp;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] beats_next;
  logic             sat_next;
  logic             flag_next;

  logic             out_valid_reg;
  logic [ACC_W-1:0] out_weight_reg;
  logic             out_flag_reg;
  logic             out_sat_reg;
  logic [ACC_W-1:0] out_beats_reg;

  // A held result freezes the whole pipeline, input side included.
  assign stall        = out_valid_reg & ~bus.out_ready;
  assign in_ready     = ~stall;
  assign accept       = bus.in_valid & in_ready;
  assign bus.in_ready = in_ready;

  always_comb begin
    pc_next = '0;
    for (int i = 0; i < N; i++) begin
      pc_next = pc_next + PC_W'(bus.in_data[i]);
    end
  end

  // Frame FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Frame FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && !bus.in_last) state_next = ACCUM;
      ACCUM:   if (accept && bus.in_last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Frame FSM: outputs. The first beat of a frame uses the live config inputs.
  always_comb begin
    cfg_load   = 1'b0;
    eff_mode   = cfg_mode_reg;
    eff_sel    = cfg_sel_reg;
    eff_thresh = cfg_thresh_reg;
    if (state_reg == IDLE) begin
      cfg_load   = accept & ~bus.in_last;
      eff_mode   = bus.mode;
      eff_sel    = bus.sel;
      eff_thresh = bus.thresh;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_mode_reg   <= '0;
      cfg_sel_reg    <= '0;
      cfg_thresh_reg <= '0;
    end else if (cfg_load) begin
      cfg_mode_reg   <= bus.mode;
      cfg_sel_reg    <= bus.sel;
      cfg_thresh_reg <= bus.thresh;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_last_reg   <= 1'b0;
      s1_pc_reg     <= '0;
      s1_mode_reg   <= '0;
      s1_sel_reg    <= '0;
      s1_thresh_reg <= '0;
    end else if (!stall) begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_last_reg   <= bus.in_last;
        s1_pc_reg     <= pc_next;
        s1_mode_reg   <= eff_mode;
        s1_sel_reg    <= eff_sel;
        s1_thresh_reg <= eff_thresh;
      end
    end
  end

  // Flag is evaluated on the clamped weight; a BIT select past the MSB shifts out to 0.
  always_comb begin
    sum_wide   = {1'b0, acc_reg} + (ACC_W + 1)'(s1_pc_reg);
    clamp      = sum_wide[ACC_W];
    acc_next   = clamp ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    sat_next   = sat_reg | clamp;
    beats_next = (&beats_reg) ? beats_reg : beats_reg + ACC_W'(1);
    flag_next  = 1'b0;
    case (s1_mode_reg)
      MODE_EQ:  flag_next = (acc_next == s1_thresh_reg);
      MODE_GE:  flag_next = (acc_next >= s1_thresh_reg);
      MODE_BIT: flag_next = |(acc_next & (ACC_W'(1) << s1_sel_reg));
      default:  flag_next = acc_next[0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg   <= '0;
      beats_reg <= '0;
      sat_reg   <= 1'b0;
    end else if (!stall && s1_valid_reg) begin
      if (s1_last_reg) begin
        acc_reg   <= '0;
        beats_reg <= '0;
        sat_reg   <= 1'b0;
      end else begin
        acc_reg   <= acc_next;
        beats_reg <= beats_next;
        sat_reg   <= sat_next;
      end
    end
  end

  // A fresh result may load on the same edge the previous one is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      out_weight_reg <= '0;
      out_flag_reg   <= 1'b0;
      out_sat_reg    <= 1'b0;
      out_beats_reg  <= '0;
    end else if (!stall) begin
      out_valid_reg <= s1_valid_reg & s1_last_reg;
      if (s1_valid_reg && s1_last_reg) begin
        out_weight_reg <= acc_next;
        out_flag_reg   <= flag_next;
        out_sat_reg    <= sat_next;
        out_beats_reg  <= beats_next;
      end
    end
  end

  assign bus.out_valid  = out_valid_reg;
  assign bus.out_weight = out_weight_reg;
  assign bus.out_flag   = out_flag_reg;
  assign bus.out_sat    = out_sat_reg;
  assign bus.out_beats  = out_beats_reg;
endmodule
